// File: rtl/stream_rx.sv
// rtl/stream_rx.sv - valid/ready packet receiver with length limiting and a FWFT beat FIFO
// Optional even-parity check on accepted beats is enabled with the STREAM_RX_PARITY_EN macro.
module stream_rx #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_LEN = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic [7:0]       o_len,
  output logic             o_err,
  output logic [15:0]      o_pkt_cnt
`ifdef STREAM_RX_PARITY_EN
  ,
  input  logic             i_parity,
  output logic             o_parity_err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, BODY, OVER} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d, len_q, len_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic            err_q, err_d;
  logic [WIDTH:0]  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [WIDTH:0]  head;
  logic            full, empty, accept, push, pop, push_last;
  logic [7:0]      cnt_inc;

  // Ready depends only on registered occupancy, so a same-cycle pop never opens a full FIFO.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign o_ready = i_rst && ((state_q == OVER) || !full);
  assign accept  = i_valid && o_ready;
  assign pop     = !empty && i_ready;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = 1'b0;
    push      = 1'b0;
    push_last = i_last;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          push = 1'b1;
          if (i_last) begin
            len_d     = 8'd1;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end else begin
            cnt_d   = 8'd1;
            state_d = BODY;
          end
        end
        BODY: begin
          push  = 1'b1;
          cnt_d = cnt_inc;
          if (i_last) begin
            len_d     = cnt_inc;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            cnt_d     = 8'd0;
            state_d   = IDLE;
          end else if (cnt_inc == 8'(MAX_LEN)) begin
            push_last = 1'b1;
            len_d     = 8'(MAX_LEN);
            state_d   = OVER;
          end
        end
        OVER: begin
          if (i_last) begin
            err_d     = 1'b1;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            cnt_d     = 8'd0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      len_q     <= 8'd0;
      pkt_cnt_q <= 16'd0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, i_data};
  end

  assign head      = mem_q[rd_ptr_q];
  assign o_valid   = !empty;
  assign o_data    = head[WIDTH-1:0];
  assign o_last    = head[WIDTH];
  assign o_len     = len_q;
  assign o_err     = err_q;
  assign o_pkt_cnt = pkt_cnt_q;

`ifdef STREAM_RX_PARITY_EN
  logic par_err_q, par_err_d, par_bad;

  assign par_bad = ((^i_data) != i_parity);

  always_comb begin
    par_err_d = par_err_q;
    if (accept) par_err_d = (state_q == IDLE) ? par_bad : (par_err_q || par_bad);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign o_parity_err = par_err_q;
`endif

endmodule
